// File: rtl/inv_key_expansion_pkg.sv
// Shared AES-128 key-schedule constants, FSM state type and byte/word helpers.
// Macro INV_KEY_EQINV_EN adds the InvMixColumns helpers for equivalent-inverse keys.
package inv_key_expansion_pkg;

  localparam logic [3:0] NUM_ROUNDS = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_e;

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] v;
    v = SBOX_FLAT[(11'd2047 - {b, 3'b000}) -: 8];
    return v;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

`ifdef INV_KEY_EQINV_EN
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] p;
    logic [7:0] a;
    p = 8'h00;
    a = b;
    for (int i = 0; i < 4; i++) begin
      if (c[i]) p = p ^ a;
      a = xtime(a);
    end
    return p;
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] w);
    logic [7:0] s0, s1, s2, s3;
    {s0, s1, s2, s3} = w;
    return {gmul(s0, 4'he) ^ gmul(s1, 4'hb) ^ gmul(s2, 4'hd) ^ gmul(s3, 4'h9),
            gmul(s0, 4'h9) ^ gmul(s1, 4'he) ^ gmul(s2, 4'hb) ^ gmul(s3, 4'hd),
            gmul(s0, 4'hd) ^ gmul(s1, 4'h9) ^ gmul(s2, 4'he) ^ gmul(s3, 4'hb),
            gmul(s0, 4'hb) ^ gmul(s1, 4'hd) ^ gmul(s2, 4'h9) ^ gmul(s3, 4'he)};
  endfunction
`endif

endpackage

// File: rtl/inv_key_expansion_sub_bytes.sv
// Byte-wise AES S-box substitution of one 32-bit word.
module inv_key_expansion_sub_bytes
  import inv_key_expansion_pkg::*;
(
  input  logic [31:0] state,
  output logic [31:0] new_state
);

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign new_state[8*i +: 8] = sbox(state[8*i +: 8]);
  end

endmodule

// File: rtl/inv_key_expansion.sv
// AES-128 key schedule emitted in reverse order (round 10 down to 0) with valid/ready.
// Macro INV_KEY_EQINV_EN: rounds 1..9 are emitted through InvMixColumns.
//
// state | meaning
// IDLE  | waiting for start
// FWD   | expanding forward one round per cycle up to round 10
// EMIT  | presenting round_key, stepping back one round per handshake
// DONE  | one-cycle completion pulse
module inv_key_expansion
  import inv_key_expansion_pkg::*;
#(
  parameter int regSize = 8,
  parameter int vecSize = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [vecSize-1:0][regSize-1:0] key,
  output logic                            busy,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [vecSize-1:0][regSize-1:0] round_key,
  output logic [3:0]                      round_idx,
  output logic                            done
);

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;

  logic [31:0]  a0, a1, a2, a3;
  logic [31:0]  sb_in, sb_out, rc_word;
  logic [31:0]  f0, f1, f2, f3;
  logic [31:0]  b0, b1, b2, b3;
  logic [127:0] emit_key;

  assign {a0, a1, a2, a3} = key_q;
  assign rc_word = {rcon(round_q), 24'h000000};

  // One S-box word path: forward needs a3, the reverse step needs a2^a3 (= new b3).
  assign sb_in = (state_q == EMIT) ? rot_word(a2 ^ a3) : rot_word(a3);

  inv_key_expansion_sub_bytes u_sub_bytes (
    .state     (sb_in),
    .new_state (sb_out)
  );

  assign f0 = a0 ^ sb_out ^ rc_word;
  assign f1 = a1 ^ f0;
  assign f2 = a2 ^ f1;
  assign f3 = a3 ^ f2;

  assign b3 = a3 ^ a2;
  assign b2 = a2 ^ a1;
  assign b1 = a1 ^ a0;
  assign b0 = a0 ^ sb_out ^ rc_word;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = key;
          round_d = 4'd1;
          state_d = FWD;
        end
      end
      FWD: begin
        key_d = {f0, f1, f2, f3};
        if (round_q == NUM_ROUNDS) begin
          state_d = EMIT;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (round_q == 4'd0) begin
            state_d = DONE;
          end else begin
            key_d   = {b0, b1, b2, b3};
            round_d = round_q - 4'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    emit_key = key_q;
`ifdef INV_KEY_EQINV_EN
    if (round_q != 4'd0 && round_q != NUM_ROUNDS) begin
      emit_key = {inv_mix_column(a0), inv_mix_column(a1),
                  inv_mix_column(a2), inv_mix_column(a3)};
    end
`endif
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == EMIT);
  assign done      = (state_q == DONE);
  assign round_idx = out_valid ? round_q : 4'd0;
  assign round_key = out_valid ? emit_key : '0;

endmodule

// File: tb/tb_inv_key_expansion.sv
// Scoreboard bench for inv_key_expansion: directed keys, stalls, start pokes, reset abort.
module tb_inv_key_expansion;

  logic clk = 1'b0;
  logic rst, start, out_ready;
  logic busy, out_valid, done;
  logic [15:0][7:0] key, round_key;
  logic [3:0] round_idx;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] k;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  logic [127:0] sched[11];
  logic [127:0] got[11];
  logic         stalled = 1'b0;
  logic [127:0] held_key;
  logic [3:0]   held_idx;

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;

  localparam logic [2047:0] TB_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  localparam logic [79:0] TB_RCON = 80'h01020408102040801b36;

  inv_key_expansion dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key       (key),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .round_key (round_key),
    .round_idx (round_idx),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] tb_sb(input logic [7:0] b);
    logic [2047:0] t;
    t = TB_SBOX;
    return t[2047 - 8*int'(b) -: 8];
  endfunction

`ifdef INV_KEY_EQINV_EN
  function automatic logic [7:0] tb_mul(input logic [7:0] b, input int c);
    logic [7:0] p, a;
    p = 8'h00;
    a = b;
    for (int i = 0; i < 4; i++) begin
      if (c[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] tb_imc(input logic [127:0] k);
    logic [127:0] r;
    logic [7:0] s0, s1, s2, s3;
    for (int c = 0; c < 4; c++) begin
      {s0, s1, s2, s3} = k[127-32*c -: 32];
      r[127-32*c -: 32] = {
        tb_mul(s0, 14) ^ tb_mul(s1, 11) ^ tb_mul(s2, 13) ^ tb_mul(s3, 9),
        tb_mul(s0, 9)  ^ tb_mul(s1, 14) ^ tb_mul(s2, 11) ^ tb_mul(s3, 13),
        tb_mul(s0, 13) ^ tb_mul(s1, 9)  ^ tb_mul(s2, 14) ^ tb_mul(s3, 11),
        tb_mul(s0, 11) ^ tb_mul(s1, 13) ^ tb_mul(s2, 9)  ^ tb_mul(s3, 14)};
    end
    return r;
  endfunction
`endif

  // Plain forward FIPS-197 expansion; expectations are queued in emission order.
  task automatic queue_schedule(input logic [127:0] k0);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [79:0] rc;
    logic [127:0] e;
    rc = TB_RCON;
    for (int i = 0; i < 4; i++) w[i] = k0[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {tb_sb(t[31:24]), tb_sb(t[23:16]), tb_sb(t[15:8]), tb_sb(t[7:0])}
            ^ {rc[79 - 8*(i/4 - 1) -: 8], 24'h000000};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    for (int r = 10; r >= 0; r--) begin
      e = sched[r];
`ifdef INV_KEY_EQINV_EN
      if (r != 0 && r != 10) e = tb_imc(e);
`endif
      sb.push_back('{idx: 4'(r), k: e});
    end
    for (int r = 0; r < 11; r++) got[r] = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per handshake, and checks stability while stalled.
  always @(negedge clk) begin
    if (out_valid && stalled) begin
      checks++;
      if (round_key !== held_key || round_idx !== held_idx) begin
        errors++;
        $display("FAIL stall_stable: got idx %0d key %h expected idx %0d key %h",
                 round_idx, round_key, held_idx, held_key);
      end
    end
    stalled  <= out_valid && !out_ready;
    held_key <= round_key;
    held_idx <= round_idx;
    if (out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_key: got idx %0d key %h expected no output", round_idx, round_key);
      end else begin
        mon_e = sb.pop_front();
        if (round_idx !== mon_e.idx || round_key !== mon_e.k) begin
          errors++;
          $display("FAIL round_key: got idx %0d key %h expected idx %0d key %h",
                   round_idx, round_key, mon_e.idx, mon_e.k);
        end
        if (round_idx <= 4'd10) got[round_idx] = round_key;
      end
    end
  end

  // ready_mode 0: out_ready held high; 1: random. poke: pulse start in FWD and EMIT.
  task automatic run(input logic [127:0] k, input int ready_mode, input bit poke, input bit timing);
    int first_valid;
    int done_cyc;
    int cyc;
    queue_schedule(k);
    key   = k;
    start = 1'b1;
    tick();
    start = 1'b0;
    first_valid = -1;
    done_cyc    = -1;
    for (cyc = 1; cyc < 300 && done_cyc < 0; cyc++) begin
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (done) done_cyc = cyc;
      out_ready = (ready_mode == 0) ? 1'b1 : 1'(($urandom_range(0, 1)));
      start     = (poke && (cyc == 4 || cyc == 14)) ? 1'b1 : 1'b0;
      tick();
    end
    start     = 1'b0;
    out_ready = 1'b0;
    if (done_cyc < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done in 300 cycles expected done pulse");
    end else begin
      if (timing) begin
        check("first_valid_cycle", 128'(first_valid), 128'd11);
        check("done_cycle", 128'(done_cyc), 128'd22);
      end
      check("done_one_cycle", {127'd0, done}, 128'd0);
      check("idle_after_done", {127'd0, busy}, 128'd0);
    end
    check("all_keys_emitted", 128'(sb.size()), 128'd0);
    check("idx0_equals_key", got[0], k);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    key = '0;
    tick();
    tick();
    check("reset_busy", {127'd0, busy}, 128'd0);
    check("reset_valid", {127'd0, out_valid}, 128'd0);
    check("reset_done", {127'd0, done}, 128'd0);
    check("reset_idx", {124'd0, round_idx}, 128'd0);
    check("reset_key", round_key, 128'd0);
    rst = 1'b0;
    tick();

    run(KEY_A, 0, 1'b0, 1'b1);
    check("keyA_round10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`ifndef INV_KEY_EQINV_EN
    check("keyA_round1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
`endif
    tick();

    run(KEY_B, 0, 1'b0, 1'b1);
    check("keyB_round10", got[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    tick();

    run(KEY_B, 1, 1'b0, 1'b0);
    tick();

    run(KEY_A, 0, 1'b1, 1'b1);
    tick();

    // Abort in EMIT at round 5.
    queue_schedule(KEY_A);
    key = KEY_A;
    start = 1'b1;
    tick();
    start = 1'b0;
    out_ready = 1'b1;
    for (n = 0; n < 40 && !(out_valid && round_idx == 4'd5); n++) tick();
    out_ready = 1'b0;
    check("reached_idx5", {127'd0, out_valid && round_idx == 4'd5}, 128'd1);
    rst = 1'b1;
    tick();
    check("abort_busy", {127'd0, busy}, 128'd0);
    check("abort_valid", {127'd0, out_valid}, 128'd0);
    check("abort_done", {127'd0, done}, 128'd0);
    check("abort_idx", {124'd0, round_idx}, 128'd0);
    check("abort_key", round_key, 128'd0);
    check("abort_remaining", 128'(sb.size()), 128'd6);
    sb.delete();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    check("no_emit_after_abort", {126'd0, out_valid, busy}, 128'd0);
    out_ready = 1'b0;
    run(KEY_A, 0, 1'b0, 1'b1);
    tick();

    check("queue_empty", 128'(sb.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
